// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MAR/MDR memory-access unit.
// Holds the FSM state encodings and the wait-counter sizing rule.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2
  } accState_e;

  localparam int unsigned MaxWaitStates = 15;

  // Wait counter is never narrower than one bit, even with zero wait states.
  function automatic int unsigned cntWidth(int unsigned waitStates);
    return (waitStates < 2) ? 1 : $clog2(waitStates + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath/control/RAM-facing signal bundle of the memory-access unit.
// The unit itself takes the slave view; the CPU side and RAM take the master view.
interface mem_access_unit_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 9
) ();

  logic [DataWidth-1:0] bus_in;
  logic                 MARin;
  logic                 MDRin;
  logic                 mem_read;
  logic                 mem_write;
  logic [DataWidth-1:0] mdr_q;
  logic [DataWidth-1:0] mar_q;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [AddrWidth-1:0] ram_addr;
  logic [DataWidth-1:0] ram_wdata;
  logic                 ram_re;
  logic                 ram_we;
  logic [DataWidth-1:0] ram_rdata;

  modport slave (
    input  bus_in, MARin, MDRin, mem_read, mem_write, ram_rdata,
    output mdr_q, mar_q, busy, done, err, ram_addr, ram_wdata, ram_re, ram_we
  );

  modport master (
    output bus_in, MARin, MDRin, mem_read, mem_write, ram_rdata,
    input  mdr_q, mar_q, busy, done, err, ram_addr, ram_wdata, ram_re, ram_we
  );

endinterface

// File: rtl/mem_access_unit_wait_counter.sv
// Non-wrapping down-counter that paces RAM wait states.
// Loaded once at access start, then counts down and parks at zero.
module mem_access_unit_wait_counter
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned WaitStates = 1,
  parameter int unsigned CntW       = cntWidth(WaitStates)
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            load,
  input  logic [CntW-1:0] startVal,
  output logic            zero
);

  logic [CntW-1:0] cntQ;

  always_ff @(posedge clock) begin
    if (clear) begin
      cntQ <= '0;
    end else if (load) begin
      cntQ <= startVal;
    end else if (cntQ != '0) begin
      cntQ <= cntQ - CntW'(1);
    end
  end

  assign zero = (cntQ == '0);

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory-access unit: sequences RAM reads/writes with wait states,
// reports busy/done to the control unit and rejects illegal requests with err.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 9,
  parameter int unsigned WaitStates = 1
) (
  input logic              clock,
  input logic              clear,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CntW = cntWidth(WaitStates);
  localparam logic [CntW-1:0] CntStart = CntW'(WaitStates);

  if (WaitStates > MaxWaitStates) begin : gBadWaitStates
    $error("mem_access_unit: WaitStates must be in 0..15");
  end
  if (AddrWidth > DataWidth) begin : gBadAddrWidth
    $error("mem_access_unit: AddrWidth must not exceed DataWidth");
  end

  accState_e            stateQ;
  logic [DataWidth-1:0] marQ;
  logic [DataWidth-1:0] mdrQ;
  logic                 busyQ;
  logic                 doneQ;
  logic                 errQ;
  logic                 reQ;
  logic                 weQ;

  logic                 addrFault;
  logic                 anyLoad;
  logic                 anyStart;
  logic                 idleReject;
  logic                 startOk;
  logic                 cntZero;

  // Upper MAR bits must be clear for the address to land inside the RAM.
  if (AddrWidth < DataWidth) begin : gAddrCheck
    assign addrFault = |marQ[DataWidth-1:AddrWidth];
  end else begin : gNoAddrCheck
    assign addrFault = 1'b0;
  end

  always_comb begin
    anyLoad    = bus.MARin | bus.MDRin;
    anyStart   = bus.mem_read | bus.mem_write;
    idleReject = (bus.mem_read & bus.mem_write) |
                 (anyStart & anyLoad) |
                 (anyStart & addrFault);
    startOk    = (stateQ == StIdle) & anyStart & ~idleReject;
  end

  mem_access_unit_wait_counter #(
    .WaitStates(WaitStates),
    .CntW      (CntW)
  ) uWaitCounter (
    .clock   (clock),
    .clear   (clear),
    .load    (startOk),
    .startVal(CntStart),
    .zero    (cntZero)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      stateQ <= StIdle;
      marQ   <= '0;
      mdrQ   <= '0;
      busyQ  <= 1'b0;
      doneQ  <= 1'b0;
      errQ   <= 1'b0;
      reQ    <= 1'b0;
      weQ    <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      errQ  <= 1'b0;
      unique case (stateQ)
        StIdle: begin
          if (anyStart && idleReject) begin
            errQ <= 1'b1;
          end else if (bus.mem_read) begin
            stateQ <= StRd;
            busyQ  <= 1'b1;
            reQ    <= 1'b1;
          end else if (bus.mem_write) begin
            stateQ <= StWr;
            busyQ  <= 1'b1;
            weQ    <= 1'b1;
          end else begin
            if (bus.MARin) marQ <= bus.bus_in;
            if (bus.MDRin) mdrQ <= bus.bus_in;
          end
        end
        StRd, StWr: begin
          // Registers stay frozen for the whole access; any request is refused.
          if (anyStart || anyLoad) errQ <= 1'b1;
          if (cntZero) begin
            stateQ <= StIdle;
            busyQ  <= 1'b0;
            reQ    <= 1'b0;
            weQ    <= 1'b0;
            doneQ  <= 1'b1;
            if (stateQ == StRd) mdrQ <= bus.ram_rdata;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign bus.mar_q     = marQ;
  assign bus.mdr_q     = mdrQ;
  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
  assign bus.err       = errQ;
  assign bus.ram_re    = reQ;
  assign bus.ram_we    = weQ;
  assign bus.ram_addr  = marQ[AddrWidth-1:0];
  assign bus.ram_wdata = mdrQ;

endmodule
